// File: rtl/mp64_spinlock.sv
// rtl/mp64_spinlock.sv - MMIO test-and-set spinlock bank with per-lock lease watchdog
// and bulk release of every lock owned by a core that is being reset.
module mp64_spinlock #(
  parameter int NUM_CORES = 4,
  parameter int NUM_LOCKS = 16,
  parameter int LEASE_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [7:0]           addr,
  input  logic [63:0]          wdata,
  input  logic                 wen,
  input  logic [1:0]           core_id,
  output logic                 ack,
  output logic [63:0]          rdata,
  input  logic [NUM_CORES-1:0] core_rst,
  output logic                 irq
);

  logic [NUM_LOCKS-1:0] held;
  logic [NUM_LOCKS-1:0] expired;
  logic [1:0]           owner [NUM_LOCKS];
  logic [LEASE_W-1:0]   cnt   [NUM_LOCKS];
  logic [1:0]           err;
  logic [LEASE_W-1:0]   lease_limit;

  logic [3:0]  idx;
  logic        is_lock, is_held, is_owner, is_exp, is_err, is_lim, bad_off;
  logic [63:0] owner_flat;
  logic [LEASE_W-1:0] limit_m1;
  logic [NUM_LOCKS-1:0] lock_sel, rel_core, rel_wr, expire, acq, exp_set, exp_clr;
  logic        bad_rel;
  logic [1:0]  err_set, err_clr;
  logic        unused_bits;

  assign unused_bits = ^{addr[2:0], wdata};

  assign idx      = addr[6:3];
  assign is_lock  = !addr[7] && ({1'b0, idx} < 5'(NUM_LOCKS));
  assign is_held  = (addr[7:3] == 5'h10);
  assign is_owner = (addr[7:3] == 5'h11);
  assign is_exp   = (addr[7:3] == 5'h12);
  assign is_err   = (addr[7:3] == 5'h13);
  assign is_lim   = (addr[7:3] == 5'h14);
  assign bad_off  = req && !(is_lock || is_held || is_owner || is_exp || is_err || is_lim);

  assign ack      = req;
  assign irq      = |expired;
  assign limit_m1 = lease_limit - LEASE_W'(1);

  always_comb begin
    owner_flat = '0;
    for (int n = 0; n < NUM_LOCKS; n++) owner_flat[2*n +: 2] = owner[n];
  end

  always_comb begin
    rdata = '0;
    if (req) begin
      if (is_lock) begin
        if (!held[idx])                rdata = core_rst[core_id] ? 64'd1 : 64'd0;
        else if (owner[idx] == core_id) rdata = 64'd2;
        else                            rdata = 64'd1;
      end
      else if (is_held)  rdata = 64'(held);
      else if (is_owner) rdata = owner_flat;
      else if (is_exp)   rdata = 64'(expired);
      else if (is_err)   rdata = 64'(err);
      else if (is_lim)   rdata = 64'(lease_limit);
    end
  end

  // Per-lock events; the ordering in the register block below encodes precedence.
  always_comb begin
    for (int n = 0; n < NUM_LOCKS; n++) begin
      lock_sel[n] = req && is_lock && (idx == 4'(n));
      rel_core[n] = held[n] && core_rst[owner[n]];
      rel_wr[n]   = lock_sel[n] && wen && held[n] && (owner[n] == core_id);
      expire[n]   = held[n] && (lease_limit != '0) && (cnt[n] >= limit_m1);
      acq[n]      = lock_sel[n] && !wen && !held[n] && !core_rst[core_id];
      exp_set[n]  = expire[n] && !rel_core[n] && !rel_wr[n];
    end
  end

  assign bad_rel = req && is_lock && wen && !(held[idx] && (owner[idx] == core_id));
  assign err_set = {bad_off, bad_rel};
  assign err_clr = (req && wen && is_err) ? wdata[1:0] : 2'b00;
  assign exp_clr = (req && wen && is_exp) ? wdata[NUM_LOCKS-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held        <= '0;
      expired     <= '0;
      err         <= '0;
      lease_limit <= '0;
      for (int n = 0; n < NUM_LOCKS; n++) begin
        owner[n] <= '0;
        cnt[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_LOCKS; n++) begin
        if (rel_core[n] || rel_wr[n] || expire[n]) begin
          held[n]  <= 1'b0;
          owner[n] <= '0;
          cnt[n]   <= '0;
        end else if (acq[n]) begin
          held[n]  <= 1'b1;
          owner[n] <= core_id;
          cnt[n]   <= '0;
        end else if (held[n] && (lease_limit != '0) && (cnt[n] != '1)) begin
          cnt[n]   <= cnt[n] + LEASE_W'(1);
        end
      end
      // Hardware sets win over a same-cycle software clear.
      expired <= (expired & ~exp_clr) | exp_set;
      err     <= (err & ~err_clr) | err_set;
      if (req && wen && is_lim) lease_limit <= wdata[LEASE_W-1:0];
    end
  end

endmodule

// File: tb/tb_mp64_spinlock.sv
// tb/tb_mp64_spinlock.sv - directed scoreboard bench for mp64_spinlock.
module tb_mp64_spinlock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [7:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic        wen = 1'b0;
  logic [1:0]  core_id = '0;
  logic        ack;
  logic [63:0] rdata;
  logic [3:0]  core_rst = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  mp64_spinlock dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .wen(wen),
    .core_id(core_id), .ack(ack), .rdata(rdata), .core_rst(core_rst), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = 'x;
    end else begin
      e = sb.pop_front();
    end
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic check_now(input string tag, input logic [63:0] obs, input logic [63:0] v);
    expect_val(tag, v);
    compare(obs);
  endtask

  task automatic bus(input logic [1:0] c, input logic [7:0] a, input logic w,
                     input logic [63:0] d, input logic chk, input logic [63:0] v,
                     input string tag);
    @(negedge clk);
    core_id = c; addr = a; wen = w; wdata = d; req = 1'b1;
    if (chk) expect_val(tag, v);
    #1;
    if (chk) compare(rdata);
    @(posedge clk);
    #1;
    req = 1'b0; wen = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] c, input logic [7:0] a, input logic [63:0] v,
                    input string tag);
    bus(c, a, 1'b0, 64'd0, 1'b1, v, tag);
  endtask

  task automatic wr(input logic [1:0] c, input logic [7:0] a, input logic [63:0] d);
    bus(c, a, 1'b1, d, 1'b0, 64'd0, "");
  endtask

  initial begin
    #1;
    check_now("idle_rdata_in_reset", rdata, 64'd0);
    check_now("irq_in_reset", 64'(irq), 64'd0);
    #12;
    @(negedge clk);
    rst = 1'b0;

    rd(0, 8'h80, 64'h0, "reset_held");
    rd(0, 8'h98, 64'h0, "reset_err");
    rd(0, 8'hA0, 64'h0, "reset_lease_limit");

    // Acquire / contention / recursion on LOCK3
    rd(0, 8'h18, 64'd0, "c0_acquire_l3");
    @(negedge clk);
    core_id = 2'd1; addr = 8'h18; wen = 1'b0; req = 1'b1;
    #1;
    check_now("ack_follows_req", 64'(ack), 64'd1);
    @(posedge clk); #1; req = 1'b0;
    rd(1, 8'h18, 64'd1, "c1_contend_l3");
    rd(0, 8'h18, 64'd2, "c0_reread_l3");
    rd(0, 8'h80, 64'h8, "held_l3");
    rd(0, 8'h88, 64'h0, "owner_l3_core0");

    // Bad release, owner release, ERR W1C
    wr(1, 8'h18, 64'hFFFF);
    rd(0, 8'h98, 64'h1, "err_bad_release");
    rd(0, 8'h80, 64'h8, "held_after_bad_release");
    wr(0, 8'h18, 64'h0);
    rd(0, 8'h80, 64'h0, "held_after_release");
    wr(0, 8'h98, 64'h1);
    rd(0, 8'h98, 64'h0, "err_cleared");

    // Lease expiry after exactly LEASE_LIMIT cycles
    wr(0, 8'hA0, 64'd10);
    rd(0, 8'hA0, 64'd10, "lease_limit_rw");
    rd(2, 8'h28, 64'd0, "c2_acquire_l5");
    for (int k = 1; k <= 10; k++) rd(0, 8'h80, 64'h20, "held_during_lease");
    rd(0, 8'h80, 64'h0, "held_after_expiry");
    rd(0, 8'h90, 64'h20, "expired_l5");
    check_now("irq_on_expiry", 64'(irq), 64'd1);
    wr(0, 8'h90, 64'h20);
    check_now("irq_after_w1c", 64'(irq), 64'd0);
    rd(0, 8'h90, 64'h0, "expired_cleared");

    // Owner release on the expiry cycle suppresses EXPIRED
    rd(2, 8'h28, 64'd0, "c2_reacquire_l5");
    for (int k = 1; k <= 9; k++) rd(0, 8'h80, 64'h20, "held_before_expiry");
    wr(2, 8'h28, 64'h0);
    rd(0, 8'h80, 64'h0, "held_release_on_expiry");
    rd(0, 8'h90, 64'h0, "expired_release_on_expiry");
    rd(0, 8'h98, 64'h0, "err_release_on_expiry");
    wr(0, 8'hA0, 64'd0);

    // Bulk release on core reset
    rd(1, 8'h00, 64'd0, "c1_acquire_l0");
    rd(1, 8'h38, 64'd0, "c1_acquire_l7");
    rd(1, 8'h78, 64'd0, "c1_acquire_l15");
    rd(0, 8'h80, 64'h8081, "held_c1_set");
    rd(0, 8'h88, 64'h4000_4001, "owner_c1_set");
    core_rst = 4'b0010;
    rd(1, 8'h10, 64'd1, "c1_acquire_during_core_rst");
    core_rst = 4'b0000;
    rd(0, 8'h80, 64'h0, "held_after_core_rst");
    rd(0, 8'h90, 64'h0, "expired_after_core_rst");
    rd(0, 8'h98, 64'h0, "err_after_core_rst");

    // Unmapped offset
    rd(0, 8'hF8, 64'h0, "unmapped_rdata");
    rd(0, 8'h98, 64'h2, "err_unmapped");

    // Async reset in the middle of a hold with the watchdog running
    wr(0, 8'hA0, 64'd3);
    rd(3, 8'h08, 64'd0, "c3_acquire_l1");
    rd(3, 8'h20, 64'd0, "c3_acquire_l4");
    rd(0, 8'h90, 64'h0, "expired_before_l1_expiry");
    rd(0, 8'h80, 64'h12, "held_l1_l4");
    check_now("irq_before_rst", 64'(irq), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1; wen = 1'b0; core_id = 2'd0; addr = 8'h80;
    #1;
    check_now("irq_async_rst", 64'(irq), 64'd0);
    check_now("held_async_rst", rdata, 64'h0);
    addr = 8'h90; #1;
    check_now("expired_async_rst", rdata, 64'h0);
    addr = 8'hA0; #1;
    check_now("lease_async_rst", rdata, 64'h0);
    addr = 8'h98; #1;
    check_now("err_async_rst", rdata, 64'h0);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
